if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Fetch stage feeding the IF/ID register: owns the PC, issues single-outstanding requests on the instruction-SRAM handshake, and delivers instrF/pc_plus_4F.
- Consumes the redirect outputs produced by decode (branch/jump/jr targets, EPC select) and the stall from the hazard unit.
- A held-instruction buffer absorbs a response that returns while the stage is stalled.

Parameters:
- RESET_PC, 32'hBFC0_0000, first fetch address after reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- StallF  in  1  hazard-unit hold; outputs frozen, redirects ignored
- branch_taken  in  1  branch in ID taken; target branch_addr
- Jump  in  1  j/jal; target jump_addr
- JumpReg  in  1  jr/jalr; target PCSrc_reg
- EPC_sel  in  1  eret; target EPC
- branch_addr  in  32  branch target
- jump_addr  in  32  jump target
- PCSrc_reg  in  32  register target
- EPC  in  32  exception return address
- inst_req  out  1  request valid
- inst_addr  out  32  request address
- inst_addr_ok  in  1  request accepted this cycle (inst_req & inst_addr_ok)
- inst_data_ok  in  1  read data valid this cycle
- inst_rdata  in  32  read data
- instrF  out  32  delivered instruction
- pc_plus_4F  out  32  delivered PC + 4
- validF  out  1  instrF/pc_plus_4F hold a live instruction
- adelF  out  1  delivered slot carries a fetch address error (feature-dependent)

Behaviour:
- Reset (rst=0, async):
  - fetch_pc=RESET_PC, state=S_REQ, discard=0, hold_valid=0.
  - inst_req=0, instrF=0, pc_plus_4F=0, validF=0, adelF=0.
  - inst_req is first asserted in the first cycle after rst deasserts.
- Redirect is honoured only when StallF=0. Priority: EPC_sel > JumpReg > Jump > branch_taken. The chosen target is loaded into fetch_pc at the clock edge.
- The redirect squashes the instruction currently in flight or held, so there is no delay-slot retention in this stage.
- FSM:
  - S_REQ: inst_req=1, inst_addr=fetch_pc.
    - On addr_ok: go to S_WAIT; fetch_pc+=4 unless a redirect occurs the same cycle.
    - Redirect on the same cycle as addr_ok: go to S_WAIT with discard=1 and fetch_pc=target.
    - Redirect without addr_ok: stay in S_REQ, fetch_pc=target.
  - S_WAIT: inst_req=0.
    - Redirect: discard=1, fetch_pc=target.
    - On data_ok with discard=1: drop data, clear discard, go to S_REQ.
    - On data_ok with discard=0 and StallF=0: load the output registers, go to S_REQ.
    - On data_ok with discard=0 and StallF=1: capture into the hold buffer, go to S_HOLD.
  - S_HOLD: inst_req=0.
    - When StallF=0: move the hold buffer into the output registers, go to S_REQ.
    - Redirect with StallF=0: drop the buffer instead, go to S_REQ.
- Output registers update only on edges where StallF=0:
  - validF=1 when loading a non-discarded instruction; validF=0 otherwise, including on a redirect edge.
  - pc_plus_4F = address of that request + 4. The request address is tracked in req_pc, captured on addr_ok.
- Steady-state throughput: one instruction per 2 cycles minimum, since a single request is outstanding.
- data_ok arriving in S_REQ (spurious) is ignored.
- StallF does not block the request handshake in S_REQ; it only blocks delivery.
- Reset mid-transaction: the state is lost. data_ok for a pre-reset request is spurious and therefore ignored.
- fetch_pc wraps modulo 2^32.

Optional Feature:
- Macro: IF_ADEL_CHECK_EN.
- Defined:
  - A fetch_pc with [1:0]!=0 issues no request; the stage waits for StallF=0.
  - It then delivers instrF=0, validF=1, adelF=1, pc_plus_4F=bad_pc+4.
  - It then idles in S_REQ with inst_req=0 until a redirect.
- Undefined:
  - inst_addr = {fetch_pc[31:2],2'b00}; adelF tied 0.

Decomposition:
- Shared package cpu_pkg:
  - state enum {S_REQ,S_WAIT,S_HOLD}
  - RESET_PC default
  - redirect-priority encoding constants
- Sub-module pc_redirect_sel: combinational priority mux producing redirect_valid and redirect_target from the four redirect requests.

Test Plan:
- Reset release with addr_ok=1 and data_ok 1 cycle later, no stall -> requests at 0xBFC00000 and 0xBFC00004; instrF=rdata; pc_plus_4F=0xBFC00004 then 0xBFC00008; validF pulses.
- data_ok arrives while StallF=1 for 3 cycles -> outputs frozen; inst_req=0; on release instrF=held word, validF=1; no lost or duplicated instruction.
- Jump with jump_addr=0x80001000 asserted during S_WAIT -> returned word discarded (validF=0); next inst_addr=0x80001000.
- EPC_sel and branch_taken in the same cycle, EPC=0x80000180, branch_addr=0x80000400 -> next request 0x80000180.
- Redirect in the same cycle as addr_ok, branch_addr=0x80000020 -> that response dropped; following request 0x80000020.
- With IF_ADEL_CHECK_EN: JumpReg with PCSrc_reg=0x80000002 -> no inst_req; adelF=1, validF=1, pc_plus_4F=0x80000006. Without the macro: inst_addr=0x80000000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: FSM states, reset vector and redirect source encoding.
// The redirect priority order is fixed here so the selector and its users agree.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef enum logic [2:0] {
        REDIR_NONE   = 3'd0,
        REDIR_BRANCH = 3'd1,
        REDIR_JUMP   = 3'd2,
        REDIR_JREG   = 3'd3,
        REDIR_EPC    = 3'd4
    } redir_src_t;

    // eret outranks jr/jalr, which outranks j/jal, which outranks a taken branch
    function automatic redir_src_t redir_pick(
        input logic epc_sel,
        input logic jump_reg,
        input logic jump,
        input logic branch_taken
    );
        if (epc_sel)           return REDIR_EPC;
        else if (jump_reg)     return REDIR_JREG;
        else if (jump)         return REDIR_JUMP;
        else if (branch_taken) return REDIR_BRANCH;
        else                   return REDIR_NONE;
    endfunction

endpackage

// File: rtl/pc_redirect_sel.sv
// Priority mux over the decode-stage redirect requests; produces one target.
module pc_redirect_sel
    import cpu_pkg::*;
(
    input  logic        EPC_sel,
    input  logic        JumpReg,
    input  logic        Jump,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    input  logic [31:0] jump_addr,
    input  logic [31:0] PCSrc_reg,
    input  logic [31:0] EPC,
    output logic        redirect_valid,
    output logic [31:0] redirect_target
);

    redir_src_t src;

    always_comb begin
        src             = redir_pick(EPC_sel, JumpReg, Jump, branch_taken);
        redirect_valid  = (src != REDIR_NONE);
        redirect_target = '0;
        case (src)
            REDIR_EPC:    redirect_target = EPC;
            REDIR_JREG:   redirect_target = PCSrc_reg;
            REDIR_JUMP:   redirect_target = jump_addr;
            REDIR_BRANCH: redirect_target = branch_addr;
            default:      redirect_target = '0;
        endcase
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC owner, single-outstanding SRAM requester, hold buffer.
// Define IF_ADEL_CHECK_EN to raise adelF on misaligned fetch addresses instead of masking them.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        branch_taken,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic        EPC_sel,
    input  logic [31:0] branch_addr,
    input  logic [31:0] jump_addr,
    input  logic [31:0] PCSrc_reg,
    input  logic [31:0] EPC,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic [31:0] instrF,
    output logic [31:0] pc_plus_4F,
    output logic        validF,
    output logic        adelF
);

    fetch_state_t state, state_next;

    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic [31:0] hold_instr;
    logic        hold_valid;
    logic        discard;

    logic        sel_valid;
    logic [31:0] sel_target;
    logic        redirect;
    logic        addr_hs;
    logic        take_resp;
    logic        deliver_now;
    logic        to_hold;
    logic        release_hold;
    logic        pc_misaligned;
    logic        adel_fire;

    pc_redirect_sel u_redirect_sel (
        .EPC_sel         (EPC_sel),
        .JumpReg         (JumpReg),
        .Jump            (Jump),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .jump_addr       (jump_addr),
        .PCSrc_reg       (PCSrc_reg),
        .EPC             (EPC),
        .redirect_valid  (sel_valid),
        .redirect_target (sel_target)
    );

    // A stalled stage must not lose its place, so redirects only land when StallF is low
    assign redirect     = sel_valid & ~StallF;
    assign addr_hs      = inst_req & inst_addr_ok;
    assign take_resp    = (state == S_WAIT) & inst_data_ok & ~discard & ~redirect;
    assign deliver_now  = take_resp & ~StallF;
    assign to_hold      = take_resp & StallF;
    assign release_hold = hold_valid & ~StallF & ~redirect;

`ifdef IF_ADEL_CHECK_EN
    logic adel_done;

    assign pc_misaligned = (fetch_pc[1:0] != 2'b00);
    assign adel_fire     = (state == S_REQ) & pc_misaligned & ~adel_done & ~StallF & ~redirect;

    // After reporting the error once the stage parks until decode redirects it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adel_done <= 1'b0;
        end else if (redirect) begin
            adel_done <= 1'b0;
        end else if (adel_fire) begin
            adel_done <= 1'b1;
        end
    end
`else
    assign pc_misaligned = 1'b0;
    assign adel_fire     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_REQ: begin
                if (addr_hs) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (inst_data_ok) state_next = to_hold ? S_HOLD : S_REQ;
            end
            S_HOLD: begin
                if (!StallF) state_next = S_REQ;
            end
            default: state_next = S_REQ;
        endcase
    end

    // Gating with rst keeps the request low while reset is held
    always_comb begin
        inst_req = rst & (state == S_REQ) & ~pc_misaligned;
`ifdef IF_ADEL_CHECK_EN
        inst_addr = fetch_pc;
`else
        inst_addr = {fetch_pc[31:2], 2'b00};
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc   <= RESET_PC;
            req_pc     <= '0;
            discard    <= 1'b0;
            hold_valid <= 1'b0;
            hold_instr <= '0;
        end else begin
            if (redirect) begin
                fetch_pc <= sel_target;
            end else if (addr_hs) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            if (addr_hs) begin
                req_pc <= fetch_pc;
            end

            // A redirect while a response is owed marks it for dropping on arrival
            if (state == S_WAIT) begin
                if (inst_data_ok) begin
                    discard <= 1'b0;
                end else if (redirect) begin
                    discard <= 1'b1;
                end
            end else if (addr_hs && redirect) begin
                discard <= 1'b1;
            end

            if (to_hold) begin
                hold_valid <= 1'b1;
                hold_instr <= inst_rdata;
            end else if (hold_valid && !StallF) begin
                hold_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instrF     <= '0;
            pc_plus_4F <= '0;
            validF     <= 1'b0;
            adelF      <= 1'b0;
        end else if (!StallF) begin
            validF <= 1'b0;
            adelF  <= 1'b0;
            if (deliver_now) begin
                instrF     <= inst_rdata;
                pc_plus_4F <= req_pc + 32'd4;
                validF     <= 1'b1;
            end else if (release_hold) begin
                instrF     <= hold_instr;
                pc_plus_4F <= req_pc + 32'd4;
                validF     <= 1'b1;
            end else if (adel_fire) begin
                instrF     <= '0;
                pc_plus_4F <= fetch_pc + 32'd4;
                validF     <= 1'b1;
                adelF      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit with a one-cycle-latency instruction SRAM model.
// Honours IF_ADEL_CHECK_EN to pick the misaligned-fetch expectations.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        StallF;
    logic        branch_taken, Jump, JumpReg, EPC_sel;
    logic [31:0] branch_addr, jump_addr, PCSrc_reg, EPC;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic [31:0] instrF, pc_plus_4F;
    logic        validF, adelF;

    if_fetch_unit #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk(clk), .rst(rst), .StallF(StallF),
        .branch_taken(branch_taken), .Jump(Jump), .JumpReg(JumpReg), .EPC_sel(EPC_sel),
        .branch_addr(branch_addr), .jump_addr(jump_addr), .PCSrc_reg(PCSrc_reg), .EPC(EPC),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .instrF(instrF), .pc_plus_4F(pc_plus_4F), .validF(validF), .adelF(adelF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        vld;
        logic        adel;
        logic [31:0] instr;
        logic [31:0] pc4;
    } dlv_t;

    dlv_t        exp_q[$];
    dlv_t        dlv_exp[$];
    dlv_t        dlv_got[$];
    logic [31:0] req_log[$];
    int          n_pass = 0;
    int          n_total = 0;

    logic        addr_ok_en, data_en, spur, pend_valid;
    logic [31:0] pend_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
    endfunction

    // One clock of stimulus: SRAM model drives its side, the scoreboard tracks what must come out
    task automatic cycle();
        logic        redir, acc, stalled;
        logic [31:0] acc_addr;
        dlv_t        g, none;
        none         = '0;
        inst_addr_ok = addr_ok_en;
        inst_data_ok = (pend_valid && data_en) || spur;
        inst_rdata   = (pend_valid && data_en) ? mem_word(pend_addr) : 32'hDEAD_BEEF;
        redir        = !StallF && (EPC_sel || JumpReg || Jump || branch_taken);
        acc          = inst_req && inst_addr_ok;
        acc_addr     = inst_addr;
        stalled      = StallF;
        @(posedge clk);
        #1;
        if (pend_valid && data_en) pend_valid = 1'b0;
        if (!stalled && validF) begin
            g = '{vld: 1'b1, adel: adelF, instr: instrF, pc4: pc_plus_4F};
            dlv_got.push_back(g);
            if (exp_q.size() != 0) dlv_exp.push_back(exp_q.pop_front());
            else dlv_exp.push_back(none);
        end
        if (redir) exp_q.delete();
        if (acc) begin
            req_log.push_back(acc_addr);
            pend_valid = 1'b1;
            pend_addr  = acc_addr;
            if (!redir) exp_q.push_back('{vld: 1'b1, adel: 1'b0, instr: mem_word(acc_addr), pc4: acc_addr + 32'd4});
        end
    endtask

    task automatic clear_redirects();
        branch_taken = 1'b0; Jump = 1'b0; JumpReg = 1'b0; EPC_sel = 1'b0;
    endtask

    task automatic drain();
        addr_ok_en = 1'b0; StallF = 1'b0; data_en = 1'b1;
        clear_redirects();
        repeat (3) cycle();
    endtask

    task automatic test_reset();
        rst = 1'b0; StallF = 1'b0; clear_redirects();
        branch_addr = '0; jump_addr = '0; PCSrc_reg = '0; EPC = '0;
        addr_ok_en = 1'b0; data_en = 1'b1; spur = 1'b0; pend_valid = 1'b0; pend_addr = '0;
        repeat (2) cycle();
        n_total++; if (inst_req !== 1'b0) $display("FAIL reset_req: got %b required 0", inst_req); else n_pass++;
        n_total++; if (validF !== 1'b0) $display("FAIL reset_valid: got %b required 0", validF); else n_pass++;
        n_total++; if (instrF !== 32'h0) $display("FAIL reset_instr: got %h required 0", instrF); else n_pass++;
        n_total++; if (pc_plus_4F !== 32'h0) $display("FAIL reset_pc4: got %h required 0", pc_plus_4F); else n_pass++;
        n_total++; if (adelF !== 1'b0) $display("FAIL reset_adel: got %b required 0", adelF); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (inst_req !== 1'b1) $display("FAIL first_req: got %b required 1", inst_req); else n_pass++;
        n_total++; if (inst_addr !== 32'hBFC0_0000) $display("FAIL first_addr: got %h required bfc00000", inst_addr); else n_pass++;
    endtask

    task automatic test_first_fetch();
        logic [3:0] vpat;
        dlv_t g, e;
        addr_ok_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            vpat[i] = validF;
        end
        n_total++; if (vpat !== 4'b1010) $display("FAIL valid_pulse: got %b required 1010", vpat); else n_pass++;
        drain();
        n_total++; if (req_log.size() != 2) $display("FAIL req_count: got %0d required 2", req_log.size()); else n_pass++;
        if (req_log.size() == 2) begin
            n_total++; if (req_log[0] !== 32'hBFC0_0000) $display("FAIL req0: got %h required bfc00000", req_log[0]); else n_pass++;
            n_total++; if (req_log[1] !== 32'hBFC0_0004) $display("FAIL req1: got %h required bfc00004", req_log[1]); else n_pass++;
        end
        n_total++; if (dlv_got.size() != 2) $display("FAIL seq_count: got %0d required 2", dlv_got.size()); else n_pass++;
        if (dlv_got.size() != 0) begin
            n_total++; if (dlv_got[0].pc4 !== 32'hBFC0_0004) $display("FAIL seq_pc4_0: got %h required bfc00004", dlv_got[0].pc4); else n_pass++;
        end
        while (dlv_got.size() != 0) begin
            g = dlv_got.pop_front(); e = dlv_exp.pop_front();
            n_total++; if (g !== e) $display("FAIL seq_dlv: got %h required %h", g, e); else n_pass++;
        end
        req_log.delete();
    endtask

    task automatic test_stall_hold();
        dlv_t g, e;
        addr_ok_en = 1'b1;
        cycle();
        cycle();
        StallF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_total++; if (instrF !== mem_word(32'hBFC0_0008) || validF !== 1'b1)
                $display("FAIL stall_frozen%0d: got %h/%b required %h/1", i, instrF, validF, mem_word(32'hBFC0_0008));
            else n_pass++;
            if (i > 0) begin
                n_total++; if (inst_req !== 1'b0) $display("FAIL hold_req%0d: got %b required 0", i, inst_req); else n_pass++;
            end
        end
        StallF = 1'b0; addr_ok_en = 1'b0;
        cycle();
        n_total++; if (instrF !== mem_word(32'hBFC0_000C) || validF !== 1'b1)
            $display("FAIL hold_release: got %h/%b required %h/1", instrF, validF, mem_word(32'hBFC0_000C));
        else n_pass++;
        drain();
        n_total++; if (dlv_got.size() != 2) $display("FAIL hold_count: got %0d required 2", dlv_got.size()); else n_pass++;
        while (dlv_got.size() != 0) begin
            g = dlv_got.pop_front(); e = dlv_exp.pop_front();
            n_total++; if (g !== e) $display("FAIL hold_dlv: got %h required %h", g, e); else n_pass++;
        end
        req_log.delete();
    endtask

    task automatic test_jump_discard();
        dlv_t g, e;
        addr_ok_en = 1'b1;
        cycle();
        addr_ok_en = 1'b0; data_en = 1'b0;
        Jump = 1'b1; jump_addr = 32'h8000_1000;
        cycle();
        Jump = 1'b0; data_en = 1'b1;
        cycle();
        n_total++; if (validF !== 1'b0) $display("FAIL jump_drop: got validF %b required 0", validF); else n_pass++;
        n_total++; if (inst_req !== 1'b1 || inst_addr !== 32'h8000_1000)
            $display("FAIL jump_addr: got %b/%h required 1/80001000", inst_req, inst_addr);
        else n_pass++;
        addr_ok_en = 1'b1;
        cycle();
        addr_ok_en = 1'b0;
        cycle();
        n_total++; if (pc_plus_4F !== 32'h8000_1004) $display("FAIL jump_pc4: got %h required 80001004", pc_plus_4F); else n_pass++;
        drain();
        n_total++; if (dlv_got.size() != 1) $display("FAIL jump_count: got %0d required 1", dlv_got.size()); else n_pass++;
        while (dlv_got.size() != 0) begin
            g = dlv_got.pop_front(); e = dlv_exp.pop_front();
            n_total++; if (g !== e) $display("FAIL jump_dlv: got %h required %h", g, e); else n_pass++;
        end
        req_log.delete();
    endtask

    task automatic test_priority();
        logic [3:0]  masks [4];
        logic [31:0] want [4];
        dlv_t g, e;
        masks = '{4'b1001, 4'b0110, 4'b0011, 4'b0001};
        want  = '{32'h8000_0180, 32'h8000_0300, 32'h8000_0500, 32'h8000_0400};
        EPC = 32'h8000_0180; PCSrc_reg = 32'h8000_0300; jump_addr = 32'h8000_0500; branch_addr = 32'h8000_0400;
        addr_ok_en = 1'b0;
        StallF = 1'b1; Jump = 1'b1;
        cycle();
        StallF = 1'b0; Jump = 1'b0;
        n_total++; if (inst_addr !== 32'h8000_1004) $display("FAIL stalled_redirect: got %h required 80001004", inst_addr); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            {EPC_sel, JumpReg, Jump, branch_taken} = masks[i];
            cycle();
            clear_redirects();
            n_total++; if (inst_addr !== want[i]) $display("FAIL prio%0d: got %h required %h", i, inst_addr, want[i]); else n_pass++;
        end
        addr_ok_en = 1'b1;
        cycle();
        addr_ok_en = 1'b0;
        cycle();
        drain();
        n_total++; if (dlv_got.size() != 1) $display("FAIL prio_count: got %0d required 1", dlv_got.size()); else n_pass++;
        while (dlv_got.size() != 0) begin
            g = dlv_got.pop_front(); e = dlv_exp.pop_front();
            n_total++; if (g !== e) $display("FAIL prio_dlv: got %h required %h", g, e); else n_pass++;
        end
        req_log.delete();
    endtask

    task automatic test_same_cycle_redirect();
        dlv_t g, e;
        addr_ok_en = 1'b1; branch_taken = 1'b1; branch_addr = 32'h8000_0020;
        cycle();
        clear_redirects(); addr_ok_en = 1'b0;
        cycle();
        n_total++; if (validF !== 1'b0 || dlv_got.size() != 0)
            $display("FAIL same_drop: got validF %b deliveries %0d required 0/0", validF, dlv_got.size());
        else n_pass++;
        n_total++; if (inst_addr !== 32'h8000_0020) $display("FAIL same_addr: got %h required 80000020", inst_addr); else n_pass++;
        addr_ok_en = 1'b1;
        cycle();
        addr_ok_en = 1'b0;
        cycle();
        drain();
        n_total++; if (dlv_got.size() != 1) $display("FAIL same_count: got %0d required 1", dlv_got.size()); else n_pass++;
        while (dlv_got.size() != 0) begin
            g = dlv_got.pop_front(); e = dlv_exp.pop_front();
            n_total++; if (g !== e) $display("FAIL same_dlv: got %h required %h", g, e); else n_pass++;
        end
        req_log.delete();
    endtask

    task automatic test_wrap();
        dlv_t g, e;
        addr_ok_en = 1'b0; Jump = 1'b1; jump_addr = 32'hFFFF_FFFC;
        cycle();
        Jump = 1'b0; addr_ok_en = 1'b1;
        cycle();
        addr_ok_en = 1'b0;
        cycle();
        n_total++; if (pc_plus_4F !== 32'h0 || validF !== 1'b1) $display("FAIL wrap_pc4: got %h/%b required 0/1", pc_plus_4F, validF); else n_pass++;
        n_total++; if (inst_addr !== 32'h0) $display("FAIL wrap_addr: got %h required 0", inst_addr); else n_pass++;
        while (dlv_got.size() != 0) begin
            g = dlv_got.pop_front(); e = dlv_exp.pop_front();
            n_total++; if (g !== e) $display("FAIL wrap_dlv: got %h required %h", g, e); else n_pass++;
        end
        req_log.delete();
    endtask

    task automatic test_reset_mid();
        addr_ok_en = 1'b1;
        cycle();
        addr_ok_en = 1'b0;
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        cycle();
        pend_valid = 1'b0;
        n_total++; if (validF !== 1'b0 || dlv_got.size() != 0)
            $display("FAIL stale_data: got validF %b deliveries %0d required 0/0", validF, dlv_got.size());
        else n_pass++;
        n_total++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0000)
            $display("FAIL rst_mid_addr: got %b/%h required 1/bfc00000", inst_req, inst_addr);
        else n_pass++;
        spur = 1'b1;
        cycle();
        spur = 1'b0;
        n_total++; if (validF !== 1'b0) $display("FAIL spurious: got validF %b required 0", validF); else n_pass++;
        dlv_got.delete(); dlv_exp.delete(); req_log.delete();
    endtask

    task automatic test_adel();
        dlv_t g, e;
        addr_ok_en = 1'b0; JumpReg = 1'b1; PCSrc_reg = 32'h8000_0002;
        cycle();
        clear_redirects();
`ifdef IF_ADEL_CHECK_EN
        n_total++; if (inst_req !== 1'b0) $display("FAIL adel_noreq: got %b required 0", inst_req); else n_pass++;
        StallF = 1'b1;
        cycle();
        StallF = 1'b0;
        n_total++; if (validF !== 1'b0) $display("FAIL adel_stall: got validF %b required 0", validF); else n_pass++;
        exp_q.push_back('{vld: 1'b1, adel: 1'b1, instr: 32'h0, pc4: 32'h8000_0006});
        cycle();
        n_total++; if (adelF !== 1'b1 || validF !== 1'b1 || pc_plus_4F !== 32'h8000_0006)
            $display("FAIL adel_out: got %b/%b/%h required 1/1/80000006", adelF, validF, pc_plus_4F);
        else n_pass++;
        addr_ok_en = 1'b1;
        cycle();
        addr_ok_en = 1'b0;
        n_total++; if (inst_req !== 1'b0 || validF !== 1'b0 || req_log.size() != 0)
            $display("FAIL adel_idle: got req %b valid %b reqs %0d required 0/0/0", inst_req, validF, req_log.size());
        else n_pass++;
`else
        n_total++; if (inst_addr !== 32'h8000_0000 || inst_req !== 1'b1)
            $display("FAIL mask_addr: got %h/%b required 80000000/1", inst_addr, inst_req);
        else n_pass++;
        n_total++; if (adelF !== 1'b0) $display("FAIL mask_adel: got %b required 0", adelF); else n_pass++;
`endif
        Jump = 1'b1; jump_addr = 32'h8000_0040;
        cycle();
        clear_redirects();
        n_total++; if (inst_req !== 1'b1 || inst_addr !== 32'h8000_0040)
            $display("FAIL adel_exit: got %b/%h required 1/80000040", inst_req, inst_addr);
        else n_pass++;
        while (dlv_got.size() != 0) begin
            g = dlv_got.pop_front(); e = dlv_exp.pop_front();
            n_total++; if (g !== e) $display("FAIL adel_dlv: got %h required %h", g, e); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall_hold();
        test_jump_discard();
        test_priority();
        test_same_cycle_redirect();
        test_wrap();
        test_reset_mid();
        test_adel();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
